// File: rtl/fft_peak_detector.sv
// Streaming peak-magnitude detector for one FFT frame; emits {flag, index, magnitude} per frame.
// Optional macro FFT_PEAK_SKIP_DC_EN excludes bin 0 from the peak search.
module fft_peak_detector #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [BIT_WIDTH-1:0] recv_msg,
    input  logic                        recv_val,
    output logic                        recv_rdy,
    output logic        [BIT_WIDTH-1:0] send_msg,
    output logic                        send_val,
    input  logic                        send_rdy,
    input  logic        [BIT_WIDTH-1:0] cfg_msg,
    input  logic                        cfg_val,
    output logic                        cfg_rdy
);

    localparam int MAG_W = BIT_WIDTH - 8;
    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [BIT_WIDTH:0] MAG_LIM = {{(BIT_WIDTH-MAG_W){1'b0}}, 1'b1, {MAG_W{1'b0}}};

    generate
        if (BIT_WIDTH < 16 || DECIMAL_PT >= BIT_WIDTH || N_SAMPLES < 2 || N_SAMPLES > 128 ||
            (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_cfg
            $error("fft_peak_detector: unsupported parameter set");
        end
    endgenerate

    typedef enum logic {ACCUM = 1'b0, SEND = 1'b1} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_count;
    logic [MAG_W-1:0]     r_peak;
    logic [IDX_W-1:0]     r_peak_idx;
    logic [MAG_W-1:0]     r_threshold;
    logic [BIT_WIDTH-1:0] r_send_msg;
    logic                 r_send_val;
    logic                 r_recv_rdy;
    logic                 r_cfg_rdy;

    logic                 w_accept;
    logic [MAG_W-1:0]     w_mag;
    logic [MAG_W-1:0]     w_new_peak;
    logic [IDX_W-1:0]     w_new_idx;
    logic [6:0]           w_idx7;
    logic                 w_flag;
    logic [BIT_WIDTH-MAG_W-1:0] w_unused_cfg;

    // Sign-extend by one bit first so the most-negative input maps to +2^(W-1).
    function automatic logic [BIT_WIDTH:0] abs_mag(input logic signed [BIT_WIDTH-1:0] x);
        logic [BIT_WIDTH:0] ext;
        ext = {x[BIT_WIDTH-1], x};
        if (x[BIT_WIDTH-1])
            abs_mag = (~ext) + (BIT_WIDTH+1)'(1);
        else
            abs_mag = ext;
    endfunction

    function automatic logic [MAG_W-1:0] sat_mag(input logic [BIT_WIDTH:0] m);
        if (m >= MAG_LIM)
            sat_mag = {MAG_W{1'b1}};
        else
            sat_mag = m[MAG_W-1:0];
    endfunction

    assign w_accept     = recv_val && r_recv_rdy;
    assign w_mag        = sat_mag(abs_mag(recv_msg));
    assign w_unused_cfg = cfg_msg[BIT_WIDTH-1:MAG_W];

    always_comb begin
        w_new_peak = r_peak;
        w_new_idx  = r_peak_idx;
`ifdef FFT_PEAK_SKIP_DC_EN
        if (r_count == IDX_W'(1) || (r_count != '0 && w_mag > r_peak)) begin
            w_new_peak = w_mag;
            w_new_idx  = r_count;
        end
`else
        if (r_count == '0 || w_mag > r_peak) begin
            w_new_peak = w_mag;
            w_new_idx  = r_count;
        end
`endif
    end

    // Flag reads the pre-edge threshold, so a same-edge cfg write only affects the next frame.
    assign w_idx7 = 7'(w_new_idx);
    assign w_flag = (w_new_peak >= r_threshold);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ACCUM;
            r_count     <= '0;
            r_peak      <= '0;
            r_peak_idx  <= '0;
            r_threshold <= '0;
            r_send_msg  <= '0;
            r_send_val  <= 1'b0;
            r_recv_rdy  <= 1'b0;
            r_cfg_rdy   <= 1'b0;
        end else begin
            r_cfg_rdy <= 1'b1;
            if (cfg_val && r_cfg_rdy)
                r_threshold <= cfg_msg[MAG_W-1:0];

            case (r_state)
                ACCUM: begin
                    r_recv_rdy <= 1'b1;
                    if (w_accept) begin
                        r_peak     <= w_new_peak;
                        r_peak_idx <= w_new_idx;
                        if (r_count == LAST_IDX) begin
                            r_count    <= '0;
                            r_state    <= SEND;
                            r_send_msg <= {w_flag, w_idx7, w_new_peak};
                            r_send_val <= 1'b1;
                            r_recv_rdy <= 1'b0;
                        end else begin
                            r_count <= r_count + IDX_W'(1);
                        end
                    end
                end
                SEND: begin
                    if (send_rdy) begin
                        r_state    <= ACCUM;
                        r_peak     <= '0;
                        r_peak_idx <= '0;
                        r_send_val <= 1'b0;
                        r_recv_rdy <= 1'b1;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign recv_rdy = r_recv_rdy;
    assign send_msg = r_send_msg;
    assign send_val = r_send_val;
    assign cfg_rdy  = r_cfg_rdy;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed self-checking bench for fft_peak_detector (BIT_WIDTH=32, N_SAMPLES=8).
// Expected results follow FFT_PEAK_SKIP_DC_EN when the bench is built with it defined.
module tb_fft_peak_detector;

    logic        clk;
    logic        reset;
    logic [31:0] recv_msg;
    logic        recv_val;
    logic        recv_rdy;
    logic [31:0] send_msg;
    logic        send_val;
    logic        send_rdy;
    logic [31:0] cfg_msg;
    logic        cfg_val;
    logic        cfg_rdy;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] frame [8];
    logic [31:0] held_msg;

    fft_peak_detector #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .cfg_msg  (cfg_msg),
        .cfg_val  (cfg_val),
        .cfg_rdy  (cfg_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Feeds frame[0..nsamp-1]; optionally pulses a cfg write on the same edge as the 8th sample.
    task automatic run_frame(input int nsamp, input bit cfg_last, input logic [31:0] cfgv);
        int waits;
        for (int i = 0; i < nsamp; i++) begin
            recv_msg = frame[i];
            recv_val = 1'b1;
            if (i == 7 && cfg_last) begin
                cfg_msg = cfgv;
                cfg_val = 1'b1;
            end
            waits = 0;
            @(negedge clk);
            while (!recv_rdy && waits < 50) begin
                waits++;
                @(negedge clk);
            end
            if (!recv_rdy) begin
                check("recv_rdy_timeout", 32'(recv_rdy), 32'd1);
                recv_val = 1'b0;
                return;
            end
            if (i == 7) check("val_before_last", 32'(send_val), 32'd0);
            @(posedge clk);
            #1;
            cfg_val = 1'b0;
        end
        recv_val = 1'b0;
        if (nsamp == 8) check("val_1cyc_after_last", 32'(send_val), 32'd1);
    endtask

    // With send_rdy high, the result must drop one cycle after it appeared.
    task automatic take_result(input string tag, input logic [31:0] exp);
        check(tag, send_msg, exp);
        @(posedge clk);
        #1;
        check({tag, "_val_drop"}, 32'(send_val), 32'd0);
        check({tag, "_rdy_back"}, 32'(recv_rdy), 32'd1);
    endtask

    task automatic cfg_write(input logic [31:0] v);
        cfg_msg = v;
        cfg_val = 1'b1;
        @(negedge clk);
        check("cfg_rdy", 32'(cfg_rdy), 32'd1);
        @(posedge clk);
        #1;
        cfg_val = 1'b0;
    endtask

    task automatic load(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
                        input logic [31:0] a6, input logic [31:0] a7);
        frame[0] = a0; frame[1] = a1; frame[2] = a2; frame[3] = a3;
        frame[4] = a4; frame[5] = a5; frame[6] = a6; frame[7] = a7;
    endtask

    initial begin
        reset    = 1'b1;
        recv_msg = '0;
        recv_val = 1'b0;
        send_rdy = 1'b1;
        cfg_msg  = '0;
        cfg_val  = 1'b0;

        // Reset state
        #12;
        check("rst_recv_rdy", 32'(recv_rdy), 32'd0);
        check("rst_cfg_rdy", 32'(cfg_rdy), 32'd0);
        check("rst_send_val", 32'(send_val), 32'd0);
        check("rst_send_msg", send_msg, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_recv_rdy", 32'(recv_rdy), 32'd1);
        check("post_rst_cfg_rdy", 32'(cfg_rdy), 32'd1);

        // 1: basic peak, threshold 0
        load(32'd0, 32'd1, 32'd2, 32'h500, 32'd3, 32'd4, 32'd5, 32'd6);
        run_frame(8, 1'b0, '0);
        take_result("t1_basic", 32'h8300_0500);

        // 2: most-negative saturates; equal magnitudes keep the earlier index
        load(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'h8000_0000, 32'd6, 32'd7);
        run_frame(8, 1'b0, '0);
        take_result("t2_sat", 32'h85FF_FFFF);
        load(32'd5, 32'd3, 32'hFFFF_FFC0, 32'd7, 32'h3F, 32'd1, 32'hFFFF_FFC0, 32'd2);
        run_frame(8, 1'b0, '0);
        take_result("t2_tie", 32'h8200_0040);

        // 3: threshold just above and exactly at the peak; upper cfg bits ignored
        cfg_write(32'h0000_1000);
        load(32'd1, 32'd2, 32'd3, 32'd4, 32'hFFF, 32'd5, 32'd6, 32'd7);
        run_frame(8, 1'b0, '0);
        take_result("t3_below_thr", 32'h0400_0FFF);
        cfg_write(32'hAB00_0FFF);
        run_frame(8, 1'b0, '0);
        take_result("t3_at_thr", 32'h8400_0FFF);

        // 4: cfg write on the last-sample edge affects only the next frame; back-pressure
        load(32'd0, 32'd1, 32'd2, 32'h500, 32'd3, 32'd4, 32'd5, 32'd6);
        send_rdy = 1'b0;
        run_frame(8, 1'b1, 32'd0);
        check("t4_old_thr_flag", send_msg, 32'h0300_0500);
        held_msg = send_msg;
        recv_msg = 32'h77;
        recv_val = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_bp_recv_rdy", 32'(recv_rdy), 32'd0);
            check("t4_bp_msg_stable", send_msg, held_msg);
            check("t4_bp_val_held", 32'(send_val), 32'd1);
        end
        send_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("t4_hs_val_drop", 32'(send_val), 32'd0);
        check("t4_idx0_ready_next", 32'(recv_rdy), 32'd1);
        load(32'h77, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7);
        run_frame(8, 1'b0, '0);
`ifdef FFT_PEAK_SKIP_DC_EN
        take_result("t4_next_frame", 32'h8700_0007);
`else
        take_result("t4_next_frame", 32'h8000_0077);
`endif

        // 5: reset mid-frame discards the partial frame
        load(32'd1, 32'h9000, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0);
        run_frame(4, 1'b0, '0);
        reset = 1'b1;
        #2;
        check("t5_rst_recv_rdy", 32'(recv_rdy), 32'd0);
        check("t5_rst_send_val", 32'(send_val), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        load(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'h10, 32'h20);
        run_frame(8, 1'b0, '0);
        take_result("t5_fresh", 32'h8700_0020);

        // 6: DC handling
        load(32'h9999, 32'd0, 32'd0, 32'h10, 32'd0, 32'd0, 32'd0, 32'd0);
        run_frame(8, 1'b0, '0);
`ifdef FFT_PEAK_SKIP_DC_EN
        take_result("t6_dc", 32'h8300_0010);
`else
        take_result("t6_dc", 32'h8000_9999);
`endif
        load(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        run_frame(8, 1'b0, '0);
`ifdef FFT_PEAK_SKIP_DC_EN
        take_result("t6_zero", 32'h8100_0000);
`else
        take_result("t6_zero", 32'h8000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
